// File: rtl/quire_pkg.sv
// -----------------------------------------------------------------------------
// quire_pkg
// Shared sizing helpers and types for the posit quire datapath.
//   nqmin(n, es)      : minimum exact quire width for posit<n,es>
//   nq(n, es, log)    : quire width including carry guard bits
//   bpp(n, es)        : binary point position inside the quire
//   quire_flags_t     : per-datum side-band flags carried down the pipeline
// No ports (package).
// -----------------------------------------------------------------------------
package quire_pkg;

   // Side-band flags that travel with an aligned datum.
   typedef struct packed {
      logic sow;
      logic eow;
      logic sign;
      logic nar;
   } quire_flags_t;

   localparam quire_flags_t QUIRE_FLAGS_CLEAR = '{sow: 1'b0, eow: 1'b0, sign: 1'b0, nar: 1'b0};

   // posit16_1 operand accumulation
   localparam int POSIT16_1_WIDTH          = 16;
   localparam int POSIT16_1_ES             = 1;
   localparam int POSIT16_1_FRACTION_WIDTH = 12;
   localparam int POSIT16_1_SCALE_WIDTH    = 6;

   // posit16_1 product accumulation (double-width fraction, wider scale)
   localparam int POSIT16_1_PROD_FRACTION_WIDTH = 26;
   localparam int POSIT16_1_PROD_SCALE_WIDTH    = 7;

   function automatic int nqmin(input int n, input int es);
      return (32'sd1 <<< (es + 32'sd2)) * (n - 32'sd2) + 32'sd1;
   endfunction

   function automatic int nq(input int n, input int es, input int log_nb_accum);
      return nqmin(n, es) + log_nb_accum;
   endfunction

   function automatic int bpp(input int n, input int es);
      return (nqmin(n, es) - 32'sd1) / 32'sd2;
   endfunction

endpackage

// File: rtl/quire_align.sv
// -----------------------------------------------------------------------------
// quire_align
// Combinational alignment shifter: places the hidden-bit mantissa of a decoded
// posit at its fixed-point position inside an NQ-bit quire word.
// Ports:
//   fraction [FRACTION_WIDTH] in  : fraction bits, hidden bit excluded
//   scale    [SCALE_WIDTH]    in  : two's-complement scale
//   zero                      in  : datum is zero, forces aligned = 0
//   nar                       in  : datum is NaR, forces aligned = 0
//   aligned  [NQ]             out : unsigned magnitude aligned to the quire
// -----------------------------------------------------------------------------
module quire_align
   import quire_pkg::*;
#(
   parameter int FRACTION_WIDTH = 12,
   parameter int SCALE_WIDTH    = 6,
   parameter int NQ             = 128,
   parameter int LSB_OFF        = 44
) (
   input  logic [FRACTION_WIDTH-1:0] fraction,
   input  logic [SCALE_WIDTH-1:0]    scale,
   input  logic                      zero,
   input  logic                      nar,
   output logic [NQ-1:0]             aligned
);

   logic signed [31:0] k_s;
   logic        [31:0] shamt_s;
   logic      [NQ-1:0] mant_s;

   // Mantissa with the hidden one restored, zero-extended to quire width.
   assign mant_s = {{(NQ - FRACTION_WIDTH - 1){1'b0}}, 1'b1, fraction};

   // k is the quire bit position of the mantissa LSB.
   assign k_s = 32'(signed'(scale)) + 32'(LSB_OFF);

   // Shift distance magnitude; direction is taken from the sign of k.
   always_comb begin
      shamt_s = 32'd0;
      if (k_s[31]) begin
         shamt_s = -k_s;
      end else begin
         shamt_s = k_s;
      end
   end

   // Right shifts drop the bits below the quire LSB; left shifts past NQ wrap off the top.
   always_comb begin
      aligned = {NQ{1'b0}};
      if (zero | nar) begin
         aligned = {NQ{1'b0}};
      end else if (k_s[31]) begin
         aligned = mant_s >> shamt_s;
      end else begin
         aligned = mant_s << shamt_s;
      end
   end

endmodule

// File: rtl/quire_window_accum.sv
// -----------------------------------------------------------------------------
// quire_window_accum
// Exact windowed accumulator for decoded posits. Data framed by sow/eow are
// aligned into an NQ-bit fixed-point quire and summed; one result per window.
// Ports:
//   clk, rst         in  : clock, asynchronous active-high reset
//   rts_i / rtr_o    in/out : upstream handshake (rtr_o registered)
//   sow_i, eow_i     in  : window framing
//   fraction, scale  in  : decoded magnitude
//   sign_i, zero_i, NaR_i in : datum attributes
//   rtr_i / rts_o    in/out : downstream handshake
//   data_o [NQ]      out : two's-complement quire, binary point at bit BPP
//   NaR_o            out : window contained a NaR
// Pipeline: input mux (skid latch first) -> align register -> accumulate
// register (window result captured here) -> output register.
// -----------------------------------------------------------------------------
module quire_window_accum
   import quire_pkg::*;
#(
   parameter int POSIT_WIDTH    = 16,
   parameter int ES             = 1,
   parameter int FRACTION_WIDTH = 12,
   parameter int SCALE_WIDTH    = 6,
   parameter int LOG_NB_ACCUM   = POSIT_WIDTH - 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       rts_i,
   output logic                                       rtr_o,
   input  logic                                       sow_i,
   input  logic                                       eow_i,
   input  logic [FRACTION_WIDTH-1:0]                  fraction,
   input  logic [SCALE_WIDTH-1:0]                     scale,
   input  logic                                       sign_i,
   input  logic                                       zero_i,
   input  logic                                       NaR_i,
   input  logic                                       rtr_i,
   output logic                                       rts_o,
   output logic [nq(POSIT_WIDTH, ES, LOG_NB_ACCUM)-1:0] data_o,
   output logic                                       NaR_o
);

   localparam int NQ      = nq(POSIT_WIDTH, ES, LOG_NB_ACCUM);
   localparam int BPP     = bpp(POSIT_WIDTH, ES);
   localparam int LSB_OFF = BPP - FRACTION_WIDTH;

   // Handshake
   logic process_en_s;
   logic xfer_s;

   // Skid latch
   logic                      skid_valid_r;
   logic [FRACTION_WIDTH-1:0] skid_frac_r;
   logic [SCALE_WIDTH-1:0]    skid_scale_r;
   logic                      skid_zero_r;
   quire_flags_t              skid_flags_r;

   // Stage-1 input selection
   logic                      in_valid_s;
   logic [FRACTION_WIDTH-1:0] in_frac_s;
   logic [SCALE_WIDTH-1:0]    in_scale_s;
   logic                      in_zero_s;
   quire_flags_t              in_flags_s;
   logic [NQ-1:0]             aligned_s;

   // Stage 1 (aligned datum)
   logic                      s1_valid_r;
   logic [NQ-1:0]             s1_aligned_r;
   quire_flags_t              s1_flags_r;

   // Stage 2 (running window state and captured window result)
   logic [NQ-1:0]             acc_r;
   logic                      nar_r;
   logic [NQ-1:0]             base_s;
   logic                      base_nar_s;
   logic [NQ-1:0]             sum_s;
   logic                      sum_nar_s;
   logic                      s2_valid_r;
   logic [NQ-1:0]             s2_data_r;
   logic                      s2_nar_r;

   // The whole pipeline advances unless a result is waiting on a stalled consumer.
   assign process_en_s = rtr_i | ~rts_o;
   assign xfer_s       = rts_i & rtr_o;

   // Upstream ready follows the enable one cycle late, so one extra datum may land in the skid latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rtr_o <= 1'b0;
      end else begin
         rtr_o <= process_en_s;
      end
   end

   // Skid latch: catches the datum transferred on the first stalled edge, drained on the next enabled edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_r <= 1'b0;
         skid_frac_r  <= {FRACTION_WIDTH{1'b0}};
         skid_scale_r <= {SCALE_WIDTH{1'b0}};
         skid_zero_r  <= 1'b0;
         skid_flags_r <= QUIRE_FLAGS_CLEAR;
      end else if (process_en_s) begin
         skid_valid_r <= 1'b0;
      end else if (xfer_s) begin
         skid_valid_r      <= 1'b1;
         skid_frac_r       <= fraction;
         skid_scale_r      <= scale;
         skid_zero_r       <= zero_i;
         skid_flags_r.sow  <= sow_i;
         skid_flags_r.eow  <= eow_i;
         skid_flags_r.sign <= sign_i;
         skid_flags_r.nar  <= NaR_i;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   // Latched datum wins; rtr_o is low whenever the latch is draining, so no live input is lost.
   always_comb begin
      in_valid_s      = 1'b0;
      in_frac_s       = fraction;
      in_scale_s      = scale;
      in_zero_s       = zero_i;
      in_flags_s      = QUIRE_FLAGS_CLEAR;
      if (skid_valid_r) begin
         in_valid_s = 1'b1;
         in_frac_s  = skid_frac_r;
         in_scale_s = skid_scale_r;
         in_zero_s  = skid_zero_r;
         in_flags_s = skid_flags_r;
      end else begin
         in_valid_s      = xfer_s;
         in_flags_s.sow  = sow_i;
         in_flags_s.eow  = eow_i;
         in_flags_s.sign = sign_i;
         in_flags_s.nar  = NaR_i;
      end
   end

   quire_align #(
      .FRACTION_WIDTH (FRACTION_WIDTH),
      .SCALE_WIDTH    (SCALE_WIDTH),
      .NQ             (NQ),
      .LSB_OFF        (LSB_OFF)
   ) u_align (
      .fraction (in_frac_s),
      .scale    (in_scale_s),
      .zero     (in_zero_s),
      .nar      (in_flags_s.nar),
      .aligned  (aligned_s)
   );

   // Stage 1: register the aligned magnitude with its flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r   <= 1'b0;
         s1_aligned_r <= {NQ{1'b0}};
         s1_flags_r   <= QUIRE_FLAGS_CLEAR;
      end else if (process_en_s) begin
         s1_valid_r   <= in_valid_s;
         s1_aligned_r <= aligned_s;
         s1_flags_r   <= in_flags_s;
      end else begin
         s1_valid_r   <= s1_valid_r;
      end
   end

   // Window sum: sow restarts from zero, otherwise continue the running sum (wraps at NQ bits).
   always_comb begin
      base_s     = acc_r;
      base_nar_s = nar_r;
      sum_s      = {NQ{1'b0}};
      if (s1_flags_r.sow) begin
         base_s     = {NQ{1'b0}};
         base_nar_s = 1'b0;
      end else begin
         base_s     = acc_r;
         base_nar_s = nar_r;
      end
      if (s1_flags_r.sign) begin
         sum_s = base_s - s1_aligned_r;
      end else begin
         sum_s = base_s + s1_aligned_r;
      end
      sum_nar_s = base_nar_s | s1_flags_r.nar;
   end

   // Stage 2: update the accumulator; on eow capture the result and clear for the next window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r      <= {NQ{1'b0}};
         nar_r      <= 1'b0;
         s2_valid_r <= 1'b0;
         s2_data_r  <= {NQ{1'b0}};
         s2_nar_r   <= 1'b0;
      end else if (process_en_s) begin
         if (s1_valid_r && s1_flags_r.eow) begin
            acc_r      <= {NQ{1'b0}};
            nar_r      <= 1'b0;
            s2_valid_r <= 1'b1;
            s2_data_r  <= sum_s;
            s2_nar_r   <= sum_nar_s;
         end else if (s1_valid_r) begin
            acc_r      <= sum_s;
            nar_r      <= sum_nar_s;
            s2_valid_r <= 1'b0;
         end else begin
            s2_valid_r <= 1'b0;
         end
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

   // Output register: a pending result is consumed (or none arrives) whenever the pipeline advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rts_o  <= 1'b0;
         data_o <= {NQ{1'b0}};
         NaR_o  <= 1'b0;
      end else if (process_en_s) begin
         rts_o <= s2_valid_r;
         if (s2_valid_r) begin
            data_o <= s2_data_r;
            NaR_o  <= s2_nar_r;
         end else begin
            data_o <= data_o;
         end
      end else begin
         rts_o <= rts_o;
      end
   end

endmodule

// File: tb/tb_quire_window_accum.sv
// -----------------------------------------------------------------------------
// tb_quire_window_accum
// Directed and randomized windows for quire_window_accum (posit16_1 operands
// with a 7-bit scale so that deep negative scales are reachable). Expected
// results come from a value-level model: each datum contributes
// (2^12 + fraction) * 2^(scale + 56 - 12) quire units, truncated, summed
// modulo 2^128 per window.
// -----------------------------------------------------------------------------
module tb_quire_window_accum;

   localparam int FW      = 12;
   localparam int SW      = 7;
   localparam int NQ      = 128;
   localparam int BPP     = 56;
   localparam int LSB_OFF = BPP - FW;

   logic          clk = 1'b0;
   logic          rst;
   logic          rts_i;
   logic          rtr_o;
   logic          sow_i;
   logic          eow_i;
   logic [FW-1:0] fraction;
   logic [SW-1:0] scale;
   logic          sign_i;
   logic          zero_i;
   logic          NaR_i;
   logic          rtr_i;
   logic          rts_o;
   logic [NQ-1:0] data_o;
   logic          NaR_o;

   typedef struct {
      logic [NQ-1:0] data;
      logic          nar;
   } result_t;

   result_t       exp_q[$];
   logic [NQ-1:0] win_sum = '0;
   logic          win_nar = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;
   logic          rnd_done = 1'b0;

   localparam logic [NQ-1:0] ONE      = 128'h0000_0000_0000_0000_0100_0000_0000_0000;
   localparam logic [NQ-1:0] THREE    = 128'h0000_0000_0000_0000_0300_0000_0000_0000;
   localparam logic [NQ-1:0] TWO      = 128'h0000_0000_0000_0000_0200_0000_0000_0000;
   localparam logic [NQ-1:0] MINUS1   = 128'hFFFF_FFFF_FFFF_FFFF_FF00_0000_0000_0000;

   always #5 clk = ~clk;

   quire_window_accum #(
      .POSIT_WIDTH    (16),
      .ES             (1),
      .FRACTION_WIDTH (FW),
      .SCALE_WIDTH    (SW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rts_i    (rts_i),
      .rtr_o    (rtr_o),
      .sow_i    (sow_i),
      .eow_i    (eow_i),
      .fraction (fraction),
      .scale    (scale),
      .sign_i   (sign_i),
      .zero_i   (zero_i),
      .NaR_i    (NaR_i),
      .rtr_i    (rtr_i),
      .rts_o    (rts_o),
      .data_o   (data_o),
      .NaR_o    (NaR_o)
   );

   task automatic chk(input string tag, input logic [NQ-1:0] obs, input logic [NQ-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Value-level reference: a datum is (1 + f/2^FW) * 2^sc, counted in units of 2^-BPP.
   task automatic model_accept(input logic sow, input logic eow, input logic [FW-1:0] f,
                               input int sc, input logic sg, input logic z, input logic n);
      logic [NQ-1:0] term;
      int            e;
      result_t       r;
      if (sow) begin
         win_sum = '0;
         win_nar = 1'b0;
      end
      term = '0;
      term[FW:0] = {1'b1, f};
      e = sc + BPP - FW;
      if (e >= 0) term = term << e;
      else        term = term >> (-e);
      if (!z && !n) win_sum = sg ? (win_sum - term) : (win_sum + term);
      win_nar = win_nar | n;
      if (eow) begin
         r.data = win_sum;
         r.nar  = win_nar;
         exp_q.push_back(r);
         win_sum = '0;
         win_nar = 1'b0;
      end
   endtask

   task automatic send(input logic sow, input logic eow, input logic [FW-1:0] f,
                       input int sc, input logic sg, input logic z, input logic n);
      int waits = 0;
      rts_i    = 1'b1;
      sow_i    = sow;
      eow_i    = eow;
      fraction = f;
      scale    = sc[SW-1:0];
      sign_i   = sg;
      zero_i   = z;
      NaR_i    = n;
      @(negedge clk);
      while (rtr_o !== 1'b1 && waits < 300) begin
         @(negedge clk);
         waits++;
      end
      chk("send_accepted", rtr_o, 1'b1);
      if (rtr_o === 1'b1) model_accept(sow, eow, f, sc, sg, z, n);
      @(posedge clk);
      #1;
      rts_i = 1'b0;
   endtask

   // Result checker: a handshake on the coming edge must match the oldest expected window.
   task automatic monitor();
      result_t r;
      forever begin
         @(negedge clk);
         if (!rst && rts_o === 1'b1 && rtr_i === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_err++;
               $error("FAIL spurious_result: observed data %h with no window pending, expected none", data_o);
            end
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               chk("result_data", data_o, r.data);
               chk("result_nar", NaR_o, r.nar);
            end
         end
      end
   endtask

   task automatic expect_after2(input string tag, input logic [NQ-1:0] val, input logic nar);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({tag, "_rts"}, rts_o, 1'b1);
      chk({tag, "_data"}, data_o, val);
      chk({tag, "_nar"}, NaR_o, nar);
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 500) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("drain_empty", 128'(exp_q.size()), '0);
      chk("drain_rts_low", rts_o, 1'b0);
   endtask

   initial begin
      int c;
      int len;
      int sc;
      rst = 1'b1; rts_i = 1'b0; rtr_i = 1'b1;
      sow_i = 1'b0; eow_i = 1'b0; fraction = '0; scale = '0;
      sign_i = 1'b0; zero_i = 1'b0; NaR_i = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rtr", rtr_o, 1'b0);
      chk("rst_rts", rts_o, 1'b0);
      chk("rst_data", data_o, '0);
      chk("rst_nar", NaR_o, 1'b0);
      rst = 1'b0;
      chk("rtr_before_edge", rtr_o, 1'b0);
      @(posedge clk); #1;
      chk("rtr_after_edge", rtr_o, 1'b1);

      // Three times 1.0, with latency check
      send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 1'b0);
      chk("lat_e0_rts", rts_o, 1'b0);
      @(posedge clk); #1;
      chk("lat_e1_rts", rts_o, 1'b0);
      @(posedge clk); #1;
      chk("lat_e2_rts", rts_o, 1'b1);
      chk("three_data", data_o, THREE);
      chk("three_nar", NaR_o, 1'b0);
      drain();

      // +1 - 1 = 0, then a one-element window of -1
      send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 1'b0);
      expect_after2("cancel", '0, 1'b0);
      send(1'b1, 1'b1, '0, 0, 1'b1, 1'b0, 1'b0);
      expect_after2("minus_one", MINUS1, 1'b0);
      drain();

      // NaR in the middle, then a clean window containing a zero datum
      send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b0, 12'h005, 3, 1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 1'b0);
      expect_after2("nar_win", TWO, 1'b1);
      send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 12'h07B, 7, 1'b0, 1'b1, 1'b0);
      expect_after2("zero_win", ONE, 1'b0);
      drain();

      // Deep negative scales: partial and full truncation
      send(1'b1, 1'b1, '0, -50, 1'b0, 1'b0, 1'b0);
      expect_after2("scale_m50", 128'h40, 1'b0);
      send(1'b1, 1'b1, '0, -60, 1'b0, 1'b0, 1'b0);
      expect_after2("scale_m60", '0, 1'b0);
      drain();

      // Downstream stall across queued windows; the last datum lands in the skid latch
      rtr_i = 1'b0;
      fork
         begin
            send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b1, '0, 2, 1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b1, '0, 3, 1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b1, '0, 4, 1'b1, 1'b0, 1'b0);
         end
         begin
            c = 0;
            while (rts_o !== 1'b1 && c < 50) begin
               @(negedge clk);
               c++;
            end
            for (int i = 0; i < 5; i++) begin
               chk("stall_rts", rts_o, 1'b1);
               chk("stall_data", data_o, TWO);
               chk("stall_nar", NaR_o, 1'b0);
               if (i >= 1) chk("stall_rtr", rtr_o, 1'b0);
               @(negedge clk);
            end
            @(posedge clk); #1;
            rtr_i = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a window discards it
      send(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b0, '0, 5, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      win_sum = '0;
      win_nar = 1'b0;
      #1;
      chk("midrst_rtr", rtr_o, 1'b0);
      chk("midrst_rts", rts_o, 1'b0);
      chk("midrst_data", data_o, '0);
      chk("midrst_nar", NaR_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send(1'b1, 1'b1, '0, 0, 1'b0, 1'b0, 1'b0);
      expect_after2("post_rst", ONE, 1'b0);
      drain();

      // Randomized windows with a randomly stalling consumer
      fork
         begin
            for (int w = 0; w < 60; w++) begin
               len = int'($urandom_range(1, 4));
               for (int j = 0; j < len; j++) begin
                  sc = int'($urandom_range(0, 127)) - 64;
                  send((j == 0) && ($urandom_range(0, 7) != 0), (j == len - 1),
                       FW'($urandom), sc, 1'($urandom),
                       ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               rtr_i = ($urandom_range(0, 3) != 0);
            end
            rtr_i = 1'b1;
         end
      join
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
